// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer.
// Handshake: load is a single-cycle strobe that the timer accepts on every
// edge it is high (there is no ready; the timer can always take a load).
// load_value is qualified only by load. en is a level, not a handshake.
// count/running/expired/done are registered status; done is a one-cycle pulse.
interface countdown_timer_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             en;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             expired;
    logic             done;
    logic [1:0]       dbg_state;  // FSM state: 0=IDLE, 1=RUN, 2=EXPIRED

    modport master (
        output load, load_value, en,
        input  count, running, expired, done, dbg_state
    );

    modport slave (
        input  load, load_value, en,
        output count, running, expired, done, dbg_state
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a prescaled tick. Counts a loaded value down to
// zero while enabled, pulses done on reaching zero, then either parks in
// EXPIRED or (AUTO_RELOAD=1) restarts from the last loaded value.
module countdown_timer #(
    parameter int WIDTH       = 8,
    parameter int PRESCALE    = 1,
    parameter int AUTO_RELOAD = 0
) (
    input  logic               clock,
    input  logic               reset,
    countdown_timer_if.slave   bus
);

    // Prescale counter width: ceil(log2(PRESCALE)), at least one bit.
    localparam int PW = (PRESCALE <= 2) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic [PW-1:0]    prescale_q;
    logic             running_q;
    logic             expired_q;
    logic             done_q;
    logic             tick;

    // A tick is the last prescale cycle of an enabled RUN period.
    assign tick = (state_q == RUN) && bus.en && (prescale_q == PS_LAST);

    // FSM, counters and registered status flags; reset > load > counting.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            reload_q   <= '0;
            prescale_q <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.load) begin
                prescale_q <= '0;
                if (bus.load_value != '0) begin
                    count_q   <= bus.load_value;
                    reload_q  <= bus.load_value;
                    state_q   <= RUN;
                    running_q <= 1'b1;
                    expired_q <= 1'b0;
                end else begin
                    // Zero load expires immediately; auto-reload does not apply.
                    count_q   <= '0;
                    state_q   <= EXPIRED;
                    running_q <= 1'b0;
                    expired_q <= 1'b1;
                    done_q    <= 1'b1;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (bus.en) begin
                            if (tick) begin
                                prescale_q <= '0;
                                if (count_q > WIDTH'(1)) begin
                                    count_q <= count_q - 1'b1;
                                end else begin
                                    // Terminal tick: count reaches zero here.
                                    done_q <= 1'b1;
                                    if (AUTO_RELOAD != 0) begin
                                        count_q <= reload_q;
                                    end else begin
                                        count_q   <= '0;
                                        state_q   <= EXPIRED;
                                        running_q <= 1'b0;
                                        expired_q <= 1'b1;
                                    end
                                end
                            end else begin
                                prescale_q <= prescale_q + 1'b1;
                            end
                        end
                    end
                    EXPIRED: begin
                        count_q <= '0;
                    end
                    default: begin
                        // IDLE holds count until a load arrives.
                    end
                endcase
            end
        end
    end

    assign bus.count     = count_q;
    assign bus.running   = running_q;
    assign bus.expired   = expired_q;
    assign bus.done      = done_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: three instances cover PRESCALE=1,
// PRESCALE=4 and AUTO_RELOAD=1, all sharing one clock and reset.
module tb_countdown_timer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    countdown_timer_if #(.WIDTH(8)) ia ();
    countdown_timer_if #(.WIDTH(8)) ib ();
    countdown_timer_if #(.WIDTH(8)) ic ();

    countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(0)) dut_a (
        .clock(clk), .reset(rst), .bus(ia.slave));
    countdown_timer #(.WIDTH(8), .PRESCALE(4), .AUTO_RELOAD(0)) dut_b (
        .clock(clk), .reset(rst), .bus(ib.slave));
    countdown_timer #(.WIDTH(8), .PRESCALE(1), .AUTO_RELOAD(1)) dut_c (
        .clock(clk), .reset(rst), .bus(ic.slave));

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge; inputs and checks happen 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ia.load = 0; ia.load_value = 0; ia.en = 0;
        ib.load = 0; ib.load_value = 0; ib.en = 0;
        ic.load = 0; ic.load_value = 0; ic.en = 0;
        step();
        step();
        chk("reset_count", ia.count, 0);
        chk("reset_running", ia.running, 0);
        chk("reset_expired", ia.expired, 0);
        chk("reset_done", ia.done, 0);
        rst = 1'b0;

        // IDLE ignores en
        ia.en = 1;
        step();
        chk("idle_en_count", ia.count, 0);
        chk("idle_en_running", ia.running, 0);

        // Load 5, PRESCALE=1: 5,4,3,2,1,0
        ia.load = 1; ia.load_value = 5;
        step();
        ia.load = 0;
        chk("l5_count", ia.count, 5);
        chk("l5_running", ia.running, 1);
        chk("l5_done", ia.done, 0);
        for (int k = 4; k >= 1; k--) begin
            step();
            chk("l5_dec_count", ia.count, k);
            chk("l5_dec_done", ia.done, 0);
        end
        step();
        chk("l5_zero_count", ia.count, 0);
        chk("l5_zero_done", ia.done, 1);
        chk("l5_zero_expired", ia.expired, 1);
        chk("l5_zero_running", ia.running, 0);
        step();
        chk("l5_after_done", ia.done, 0);
        chk("l5_after_expired", ia.expired, 1);
        ia.en = 0;
        step();
        ia.en = 1;
        step();
        chk("exp_en_count", ia.count, 0);
        chk("exp_en_expired", ia.expired, 1);
        chk("exp_en_done", ia.done, 0);

        // PRESCALE=4, load 3: done 12 cycles after load edge
        ib.en = 1; ib.load = 1; ib.load_value = 3;
        step();
        ib.load = 0;
        chk("p4_load_count", ib.count, 3);
        for (int c = 1; c <= 12; c++) begin
            step();
            chk("p4_count", ib.count, 3 - c / 4);
            chk("p4_done", ib.done, (c == 12) ? 1 : 0);
        end
        chk("p4_expired", ib.expired, 1);

        // AUTO_RELOAD=1, load 2: 2,1,2,1,... done every 2 cycles
        ic.en = 1; ic.load = 1; ic.load_value = 2;
        step();
        ic.load = 0;
        chk("ar_load_count", ic.count, 2);
        for (int c = 1; c <= 10; c++) begin
            step();
            chk("ar_count", ic.count, (c % 2 == 1) ? 1 : 2);
            chk("ar_done", ic.done, (c % 2 == 0) ? 1 : 0);
            chk("ar_expired", ic.expired, 0);
            chk("ar_running", ic.running, 1);
        end

        // Pause: load 10, 3 ticks, hold 7 cycles, resume
        ia.load = 1; ia.load_value = 10;
        step();
        ia.load = 0;
        chk("pz_load_count", ia.count, 10);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("pz_run_count", ia.count, 10 - k);
        end
        ia.en = 0;
        for (int k = 0; k < 7; k++) begin
            step();
            chk("pz_hold_count", ia.count, 7);
            chk("pz_hold_running", ia.running, 1);
            chk("pz_hold_done", ia.done, 0);
        end
        ia.en = 1;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("pz_resume_count", ia.count, 7 - k);
            chk("pz_resume_done", ia.done, (k == 7) ? 1 : 0);
            chk("pz_resume_running", ia.running, (k == 7) ? 0 : 1);
        end

        // Zero load: immediate expiry with done
        ia.load = 1; ia.load_value = 0;
        step();
        ia.load = 0;
        chk("z_count", ia.count, 0);
        chk("z_expired", ia.expired, 1);
        chk("z_done", ia.done, 1);
        chk("z_running", ia.running, 0);
        step();
        chk("z_done_clear", ia.done, 0);
        ia.load = 1; ia.load_value = 4;
        step();
        ia.load = 0;
        chk("z_reload_count", ia.count, 4);
        chk("z_reload_running", ia.running, 1);
        chk("z_reload_expired", ia.expired, 0);

        // Load 1 against a pending terminal tick: load wins, no done
        for (int k = 3; k >= 1; k--) begin
            step();
            chk("lt_count", ia.count, k);
        end
        ia.load = 1; ia.load_value = 1;
        step();
        ia.load = 0;
        chk("lt_count_after", ia.count, 1);
        chk("lt_done", ia.done, 0);
        chk("lt_running", ia.running, 1);
        step();
        chk("lt_term_count", ia.count, 0);
        chk("lt_term_done", ia.done, 1);

        // Full range: 255 counts down to 0 with no wrap
        ia.load = 1; ia.load_value = 8'hFF;
        step();
        ia.load = 0;
        chk("fr_load_count", ia.count, 255);
        for (int k = 0; k < 254; k++) step();
        chk("fr_one_count", ia.count, 1);
        chk("fr_one_done", ia.done, 0);
        step();
        chk("fr_zero_count", ia.count, 0);
        chk("fr_zero_done", ia.done, 1);
        step();
        chk("fr_hold_count", ia.count, 0);

        // Reset mid-RUN with a terminal tick pending clears done
        ia.load = 1; ia.load_value = 2;
        step();
        ia.load = 0;
        step();
        chk("rr_count_pre", ia.count, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rr_count", ia.count, 0);
        chk("rr_running", ia.running, 0);
        chk("rr_expired", ia.expired, 0);
        chk("rr_done", ia.done, 0);
        step();
        chk("rr_idle_count", ia.count, 0);
        chk("rr_idle_done", ia.done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
